// File: rtl/wb_rr_arbiter.sv
// Round-robin writeback arbiter: shares one register-file writeback port between
// NUM_UNITS execution units, with a registered output stage and a store-forwarding snoop.
module wb_rr_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int ID_W      = 3,
    parameter int XLEN      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_UNITS-1:0]      unit_done,
    input  logic [NUM_UNITS*ID_W-1:0] unit_id,
    input  logic [NUM_UNITS*XLEN-1:0] unit_rd,
    output logic [NUM_UNITS-1:0]      unit_ack,
    input  logic                      wb_ready,
    output logic                      wb_valid,
    output logic [ID_W-1:0]           wb_id,
    output logic [XLEN-1:0]           wb_data,
    output logic                      wb_snoop_valid,
    output logic [ID_W-1:0]           wb_snoop_id,
    output logic [XLEN-1:0]           wb_snoop_data
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W:0]   cand;
    logic             grant_vld;
    logic             load_en;
    logic             do_grant;
    logic [PTR_W-1:0] next_ptr;

    assign load_en  = !wb_valid || wb_ready;
    assign do_grant = load_en && grant_vld && !rst;

    // Scan from rr_ptr upward with wrap; the first requester found wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_UNITS))
                cand = cand - (PTR_W+1)'(NUM_UNITS);
            if (!grant_vld && unit_done[cand[PTR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        unit_ack = '0;
        for (int j = 0; j < NUM_UNITS; j++)
            unit_ack[j] = do_grant && (grant_idx == PTR_W'(j));
    end

    assign next_ptr = (grant_idx == PTR_W'(NUM_UNITS-1)) ? '0 : grant_idx + PTR_W'(1);

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr         <= '0;
            wb_valid       <= 1'b0;
            wb_id          <= '0;
            wb_data        <= '0;
            wb_snoop_valid <= 1'b0;
            wb_snoop_id    <= '0;
            wb_snoop_data  <= '0;
        end else begin
            wb_snoop_valid <= wb_valid && wb_ready;
            if (wb_valid && wb_ready) begin
                wb_snoop_id   <= wb_id;
                wb_snoop_data <= wb_data;
            end
            if (load_en) begin
                if (grant_vld) begin
                    wb_valid <= 1'b1;
                    wb_id    <= unit_id[int'(grant_idx)*ID_W +: ID_W];
                    wb_data  <= unit_rd[int'(grant_idx)*XLEN +: XLEN];
                    rr_ptr   <= next_ptr;
                end else begin
                    wb_valid <= 1'b0;
                end
            end
        end
    end

    a_ack_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(unit_ack));
    a_ack_has_done: assert property (@(posedge clk) disable iff (rst) (unit_ack & ~unit_done) == '0);
    a_no_ack_stall: assert property (@(posedge clk) disable iff (rst) !load_en |-> unit_ack == '0);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: a 4-unit instance driven by directed
// sequences with a packet scoreboard, plus a single-unit instance.
module tb_wb_rr_arbiter;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] data;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst;

    logic [3:0]  unit_done;
    logic [11:0] unit_id;
    logic [127:0] unit_rd;
    logic [3:0]  unit_ack;
    logic        wb_ready;
    logic        wb_valid;
    logic [2:0]  wb_id;
    logic [31:0] wb_data;
    logic        wb_snoop_valid;
    logic [2:0]  wb_snoop_id;
    logic [31:0] wb_snoop_data;

    logic        d1_done;
    logic [2:0]  d1_id;
    logic [31:0] d1_rd;
    logic        d1_ack;
    logic        d1_ready;
    logic        d1_valid;
    logic [2:0]  d1_wb_id;
    logic [31:0] d1_wb_data;
    logic        d1_snoop_valid;
    logic [2:0]  d1_snoop_id;
    logic [31:0] d1_snoop_data;

    logic [2:0]  u_id [4];
    logic [31:0] u_rd [4];
    logic [3:0]  pend;
    logic [3:0]  ack_s;

    pkt_t q  [$];
    pkt_t q1 [$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        unit_id = '0;
        unit_rd = '0;
        for (int j = 0; j < 4; j++) begin
            unit_id[j*3 +: 3]   = u_id[j];
            unit_rd[j*32 +: 32] = u_rd[j];
        end
    end

    wb_rr_arbiter #(.NUM_UNITS(4), .ID_W(3), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .unit_done(unit_done), .unit_id(unit_id), .unit_rd(unit_rd), .unit_ack(unit_ack),
        .wb_ready(wb_ready), .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
        .wb_snoop_valid(wb_snoop_valid), .wb_snoop_id(wb_snoop_id), .wb_snoop_data(wb_snoop_data)
    );

    wb_rr_arbiter #(.NUM_UNITS(1), .ID_W(3), .XLEN(32)) dut1 (
        .clk(clk), .rst(rst),
        .unit_done(d1_done), .unit_id(d1_id), .unit_rd(d1_rd), .unit_ack(d1_ack),
        .wb_ready(d1_ready), .wb_valid(d1_valid), .wb_id(d1_wb_id), .wb_data(d1_wb_data),
        .wb_snoop_valid(d1_snoop_valid), .wb_snoop_id(d1_snoop_id), .wb_snoop_data(d1_snoop_data)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboards: a handshake is seen at the negedge before the edge that takes it.
    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            check("sb_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                pkt_t p;
                p = q.pop_front();
                check("sb_id", 64'(wb_id), 64'(p.id));
                check("sb_data", 64'(wb_data), 64'(p.data));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && d1_valid && d1_ready) begin
            check("sb1_nonempty", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
                pkt_t p;
                p = q1.pop_front();
                check("sb1_id", 64'(d1_wb_id), 64'(p.id));
                check("sb1_data", 64'(d1_wb_data), 64'(p.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // One cycle: check the combinational ack at the negedge, retire acked units after the edge.
    task automatic cyc(input logic [3:0] exp_ack, input string tag);
        @(negedge clk);
        check(tag, 64'(unit_ack), 64'(exp_ack));
        ack_s = unit_ack;
        @(posedge clk);
        #1;
        pend      = pend & ~ack_s;
        unit_done = pend;
    endtask

    task automatic present(input int j, input logic [2:0] id, input logic [31:0] rd);
        u_id[j] = id;
        u_rd[j] = rd;
        pend[j] = 1'b1;
    endtask

    task automatic push(input logic [2:0] id, input logic [31:0] rd);
        pkt_t p;
        p.id   = id;
        p.data = rd;
        q.push_back(p);
    endtask

    initial begin
        logic [2:0] k1;
        logic       rp [7];
        logic       ea [7];
        rst = 1'b1;
        pend = 4'b1111;
        unit_done = 4'b1111;
        wb_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            u_id[j] = 3'(j);
            u_rd[j] = 32'hA0 + 32'(j);
        end
        d1_done = 1'b1; d1_id = '0; d1_rd = '0; d1_ready = 1'b1;

        // Reset state, with requests already pending
        #2;
        check("rst_ack", 64'(unit_ack), 64'd0);
        check("rst_ack1", 64'(d1_ack), 64'd0);
        check("rst_valid", 64'(wb_valid), 64'd0);
        check("rst_id", 64'(wb_id), 64'd0);
        check("rst_data", 64'(wb_data), 64'd0);
        check("rst_snoop_valid", 64'(wb_snoop_valid), 64'd0);
        d1_done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // All four units done: strict rotation 0,1,2,3
        for (int j = 0; j < 4; j++) push(3'(j), 32'hA0 + 32'(j));
        cyc(4'b0001, "t1_ack0");
        cyc(4'b0010, "t1_ack1");
        cyc(4'b0100, "t1_ack2");
        cyc(4'b1000, "t1_ack3");
        cyc(4'b0000, "t1_drain");
        check("t1_idle_valid", 64'(wb_valid), 64'd0);

        // Pointer is back at 0: units 0 and 3 resolve to 0 first
        present(0, 3'd4, 32'h40); present(3, 3'd7, 32'h70); unit_done = pend;
        push(3'd4, 32'h40); push(3'd7, 32'h70);
        cyc(4'b0001, "t1b_ack0");
        cyc(4'b1000, "t1b_ack3");
        cyc(4'b0000, "t1b_drain");

        // Move pointer to 2, then units 0 and 3: 3 wins, then 0 (pointer ends at 1)
        present(1, 3'd1, 32'h11); unit_done = pend; push(3'd1, 32'h11);
        cyc(4'b0010, "t2_ack1");
        cyc(4'b0000, "t2_drain0");
        present(0, 3'd2, 32'h20); present(3, 3'd3, 32'h30); unit_done = pend;
        push(3'd3, 32'h30); push(3'd2, 32'h20);
        cyc(4'b1000, "t2_ack3");
        cyc(4'b0001, "t2_ack0");
        cyc(4'b0000, "t2_drain1");
        present(0, 3'd0, 32'h01); present(1, 3'd5, 32'h51); unit_done = pend;
        push(3'd5, 32'h51); push(3'd0, 32'h01);
        cyc(4'b0010, "t2_ptr1_ack1");
        cyc(4'b0001, "t2_ptr1_ack0");
        cyc(4'b0000, "t2_drain2");

        // Backpressure: packet holds for 3 stalled cycles, queued unit waits for the handshake
        wb_ready = 1'b0;
        present(1, 3'd5, 32'hDEADBEEF); unit_done = pend;
        push(3'd5, 32'hDEADBEEF); push(3'd1, 32'h22);
        cyc(4'b0010, "bp_ack1");
        present(2, 3'd1, 32'h22); unit_done = pend;
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0000, "bp_stall_ack");
            check("bp_hold_valid", 64'(wb_valid), 64'd1);
            check("bp_hold_id", 64'(wb_id), 64'd5);
            check("bp_hold_data", 64'(wb_data), 64'hDEADBEEF);
            check("bp_snoop_idle", 64'(wb_snoop_valid), 64'd0);
        end
        wb_ready = 1'b1;
        cyc(4'b0100, "bp_ack2_on_hs");
        cyc(4'b0000, "bp_drain");

        // Snoop: handshake of id 6 / 0x1234, visible one cycle later, then idles
        present(0, 3'd6, 32'h1234); unit_done = pend; push(3'd6, 32'h1234);
        cyc(4'b0001, "sn_ack0");
        cyc(4'b0000, "sn_hs");
        check("sn_valid", 64'(wb_snoop_valid), 64'd1);
        check("sn_id", 64'(wb_snoop_id), 64'd6);
        check("sn_data", 64'(wb_snoop_data), 64'h1234);
        cyc(4'b0000, "sn_idle");
        check("sn_valid_drop", 64'(wb_snoop_valid), 64'd0);
        check("sn_id_hold", 64'(wb_snoop_id), 64'd6);

        // Async reset mid-cycle while a stalled packet is pending
        wb_ready = 1'b0;
        present(2, 3'd3, 32'h33); unit_done = pend;
        cyc(4'b0100, "ar_ack2");
        check("ar_pre_valid", 64'(wb_valid), 64'd1);
        #3;
        pend = 4'b1111; unit_done = pend;
        rst = 1'b1;
        #1;
        check("ar_valid", 64'(wb_valid), 64'd0);
        check("ar_id", 64'(wb_id), 64'd0);
        check("ar_data", 64'(wb_data), 64'd0);
        check("ar_snoop_id", 64'(wb_snoop_id), 64'd0);
        check("ar_snoop_data", 64'(wb_snoop_data), 64'd0);
        check("ar_ack", 64'(unit_ack), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wb_ready = 1'b1;
        pend = 4'b0000;
        present(1, 3'd2, 32'h12); present(3, 3'd4, 32'h34); unit_done = pend;
        push(3'd2, 32'h12); push(3'd4, 32'h34);
        cyc(4'b0010, "ar_first_from0");
        cyc(4'b1000, "ar_second");
        cyc(4'b0000, "ar_drain");
        check("sb_empty", 64'(q.size()), 64'd0);

        // Single unit: done held, ready toggling; acks only when the stage can load
        rp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        ea = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            pkt_t p;
            p.id = 3'(i);
            p.data = 32'h100 + 32'(i);
            q1.push_back(p);
        end
        k1 = '0;
        for (int i = 0; i < 7; i++) begin
            logic a;
            d1_ready = rp[i];
            d1_done  = (i < 6);
            d1_id    = k1;
            d1_rd    = 32'h100 + 32'(k1);
            @(negedge clk);
            check("u1_ack", 64'(d1_ack), 64'(ea[i]));
            a = d1_ack;
            @(posedge clk); #1;
            if (a) k1 = k1 + 3'd1;
        end
        check("u1_idle_valid", 64'(d1_valid), 64'd0);
        check("sb1_empty", 64'(q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
